// File: rtl/sd_clk_ctrl_if.sv
// rtl/sd_clk_ctrl_if.sv - SD clock controller signal bundle; ocnt present only with SD_CLK_EDGE_CNT_EN
interface sd_clk_ctrl_if;
  logic        ifastclk;
  logic        islowclk;
  logic        isel_fast;
  logic        ien;
  logic        osdclk;
  logic        orise;
  logic        ofall;
  logic        ofast;
  logic        ostopped;
`ifdef SD_CLK_EDGE_CNT_EN
  logic [15:0] ocnt;

  modport master (
    output ifastclk, islowclk, isel_fast, ien,
    input  osdclk, orise, ofall, ofast, ostopped, ocnt
  );

  modport slave (
    input  ifastclk, islowclk, isel_fast, ien,
    output osdclk, orise, ofall, ofast, ostopped, ocnt
  );
`else
  modport master (
    output ifastclk, islowclk, isel_fast, ien,
    input  osdclk, orise, ofall, ofast, ostopped
  );

  modport slave (
    input  ifastclk, islowclk, isel_fast, ien,
    output osdclk, orise, ofall, ofast, ostopped
  );
`endif
endinterface

// File: rtl/sd_clk_ctrl.sv
// rtl/sd_clk_ctrl.sv - glitch-free SD card clock gate/mux over divider levels
// Optional rising-edge counter ocnt enabled by macro SD_CLK_EDGE_CNT_EN.
module sd_clk_ctrl (
  input  logic         iclk,
  input  logic         irst,
  sd_clk_ctrl_if.slave bus
);
  localparam logic [1:0] STOP   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       fast_nxt;
  logic       sdclk_nxt;
  logic       src;
  logic       req_src;

  assign src     = bus.ofast     ? bus.ifastclk : bus.islowclk;
  assign req_src = bus.isel_fast ? bus.ifastclk : bus.islowclk;

  // Every state change happens on a low source level, so osdclk never
  // starts or ends a phase early.
  always_comb begin
    state_nxt = state;
    fast_nxt  = bus.ofast;
    sdclk_nxt = 1'b0;
    case (state)
      STOP: begin
        fast_nxt = bus.isel_fast;
        if (bus.ien && !src && (bus.isel_fast == bus.ofast))
          state_nxt = RUN;
      end
      RUN: begin
        sdclk_nxt = src;
        if (!src) begin
          if (!bus.ien)
            state_nxt = STOP;
          else if (bus.isel_fast != bus.ofast)
            state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        if (!bus.ien) begin
          state_nxt = STOP;
        end else if (!req_src) begin
          fast_nxt  = bus.isel_fast;
          state_nxt = RUN;
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state      <= STOP;
      bus.osdclk <= 1'b0;
      bus.orise  <= 1'b0;
      bus.ofall  <= 1'b0;
      bus.ofast  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus.osdclk <= sdclk_nxt;
      bus.orise  <= sdclk_nxt & ~bus.osdclk;
      bus.ofall  <= ~sdclk_nxt & bus.osdclk;
      bus.ofast  <= fast_nxt;
    end
  end

  assign bus.ostopped = (state == STOP);

`ifdef SD_CLK_EDGE_CNT_EN
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst)
      bus.ocnt <= 16'h0000;
    else if (bus.orise)
      bus.ocnt <= bus.ocnt + 16'h0001;
  end
`endif

endmodule
